// File: rtl/bias_add_bank_pkg.sv
// bias_add_bank_pkg
// Shared definitions for the bias-add bank:
//   - default lane count, data width and group count
//   - LOAD/RUN controller state encoding
//   - saturation limits for the default width
//   - clog2_min1(): index width that never drops below one bit
package bias_add_bank_pkg;

  localparam int DEF_WIDTH        = 18;
  localparam int DEF_N_ADDER_TREE = 16;
  localparam int DEF_GROUPS       = 8;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Two's-complement limits at DEF_WIDTH; the lane adder derives the same
  // shape of constant for whatever WIDTH it is built with.
  localparam logic [DEF_WIDTH-1:0] SAT_MAX_DEF = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SAT_MIN_DEF = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  function automatic int clog2_min1(input int value);
    if (value <= 1) begin
      return 1;
    end else begin
      return $clog2(value);
    end
  endfunction

endpackage

// File: rtl/bias_add_bank_lane.sv
// bias_lane_add
// One lane of the bias bank: adds a stored bias to a lane sum at WIDTH+1
// bits, then either saturates or wraps back to WIDTH bits.
// Optional feature macro: BIAS_SAT_EN (saturate instead of wrap).
// Ports:
//   bias     in  WIDTH  stored bias for this lane/group
//   lane_sum in  WIDTH  adder-tree lane sum
//   result   out WIDTH  biased lane value (combinational)
module bias_lane_add
  import bias_add_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] bias,
  input  logic [WIDTH-1:0] lane_sum,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH:0] sum_ext_s;

  // Sign-extend both operands so the add cannot lose the true result.
  assign sum_ext_s = {bias[WIDTH-1], bias} + {lane_sum[WIDTH-1], lane_sum};

`ifdef BIAS_SAT_EN
  localparam logic [WIDTH-1:0] MAX_C = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_C = {1'b1, {(WIDTH-1){1'b0}}};

  // Overflow shows up as the two top bits disagreeing; the top bit gives the true sign.
  always_comb begin
    result = sum_ext_s[WIDTH-1:0];
    if (sum_ext_s[WIDTH] != sum_ext_s[WIDTH-1]) begin
      if (sum_ext_s[WIDTH]) begin
        result = MIN_C;
      end else begin
        result = MAX_C;
      end
    end else begin
      result = sum_ext_s[WIDTH-1:0];
    end
  end
`else
  logic unused_msb_s;
  assign unused_msb_s = sum_ext_s[WIDTH];

  // Wrap: keep the low WIDTH bits of the extended sum.
  always_comb begin
    result = sum_ext_s[WIDTH-1:0];
  end
`endif

endmodule

// File: rtl/bias_add_bank.sv
// bias_add_bank
// Holds N_adder_tree*GROUPS biases and adds one group of them to each
// accepted lane-sum beat, cycling through the groups beat by beat.
// Optional feature macro: BIAS_SAT_EN (per-lane saturation instead of wrap).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load_valid/load_data bias load stream, one bias per cycle (LOAD only)
//   reload              pulse: drop stored biases, restart loading
//   load_done           high while the full bias set is loaded (RUN)
//   in_valid/in_data    lane-sum beats; in_ready high only in RUN
//   out_valid/out_data  biased lanes, one cycle after acceptance
//   grp_idx             group applied to the next accepted beat
module bias_add_bank
  import bias_add_bank_pkg::*;
#(
  parameter int N_adder_tree = DEF_N_ADDER_TREE,
  parameter int WIDTH        = DEF_WIDTH,
  parameter int GROUPS       = DEF_GROUPS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_valid,
  input  logic [WIDTH-1:0]                load_data,
  input  logic                            reload,
  output logic                            load_done,
  input  logic                            in_valid,
  input  logic [N_adder_tree*WIDTH-1:0]   in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  output logic [N_adder_tree*WIDTH-1:0]   out_data,
  output logic [clog2_min1(GROUPS)-1:0]   grp_idx
);

  localparam int GW = clog2_min1(GROUPS);
  localparam int LW = clog2_min1(N_adder_tree);

  state_e                          state_r;
  state_e                          state_nx_s;
  // The load address is kept as (group, lane) so no divide is needed.
  logic [LW-1:0]                   load_lane_r;
  logic [GW-1:0]                   load_grp_r;
  logic [GW-1:0]                   grp_r;
  logic                            load_done_r;
  logic                            in_ready_r;
  logic                            out_valid_r;
  logic [N_adder_tree*WIDTH-1:0]   out_data_r;
  logic [WIDTH-1:0]                bias_mem_r [GROUPS][N_adder_tree];
  logic [N_adder_tree*WIDTH-1:0]   lane_res_s;
  logic                            last_lane_s;
  logic                            last_grp_s;
  logic                            wr_en_s;
  logic                            accept_s;

  assign last_lane_s = (load_lane_r == LW'(N_adder_tree - 1));
  assign last_grp_s  = (load_grp_r == GW'(GROUPS - 1));
  // in_ready_r is only high in RUN, so this also ignores in_valid during LOAD.
  assign accept_s    = in_ready_r & in_valid;

  // Next-state and bias-write decode for the LOAD/RUN controller.
  always_comb begin
    state_nx_s = state_r;
    wr_en_s    = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (reload) begin
          state_nx_s = ST_LOAD;
          wr_en_s    = 1'b0;
        end else if (load_valid) begin
          wr_en_s = 1'b1;
          if (last_lane_s && last_grp_s) begin
            state_nx_s = ST_RUN;
          end else begin
            state_nx_s = ST_LOAD;
          end
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_LOAD;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Load address, group pointer and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_lane_r <= '0;
      load_grp_r  <= '0;
      grp_r       <= '0;
      load_done_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      load_done_r <= (state_nx_s == ST_RUN);
      in_ready_r  <= (state_nx_s == ST_RUN);
      if (reload) begin
        load_lane_r <= '0;
        load_grp_r  <= '0;
      end else if (wr_en_s) begin
        // The final write wraps the address back to zero.
        if (last_lane_s) begin
          load_lane_r <= '0;
          if (last_grp_s) begin
            load_grp_r <= '0;
          end else begin
            load_grp_r <= load_grp_r + GW'(1'b1);
          end
        end else begin
          load_lane_r <= load_lane_r + LW'(1'b1);
        end
      end else begin
        load_lane_r <= load_lane_r;
        load_grp_r  <= load_grp_r;
      end
      // A beat accepted alongside reload still uses the current group.
      if (reload) begin
        grp_r <= '0;
      end else if (accept_s) begin
        if (grp_r == GW'(GROUPS - 1)) begin
          grp_r <= '0;
        end else begin
          grp_r <= grp_r + GW'(1'b1);
        end
      end else begin
        grp_r <= grp_r;
      end
    end
  end

  // Bias storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      bias_mem_r[load_grp_r][load_lane_r] <= load_data;
    end
  end

  genvar k;
  generate
    for (k = 0; k < N_adder_tree; k++) begin : g_lane
      bias_lane_add #(
        .WIDTH (WIDTH)
      ) u_lane (
        .bias     (bias_mem_r[grp_r][k]),
        .lane_sum (in_data[WIDTH*k +: WIDTH]),
        .result   (lane_res_s[WIDTH*k +: WIDTH])
      );
    end
  endgenerate

  // Output register: one-cycle latency, data held between beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      out_valid_r <= accept_s;
      if (accept_s) begin
        out_data_r <= lane_res_s;
      end else begin
        out_data_r <= out_data_r;
      end
    end
  end

  assign load_done = load_done_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign grp_idx   = grp_r;

endmodule

// File: tb/tb_bias_add_bank.sv
module tb_bias_add_bank;

  localparam int N = 16;
  localparam int W = 18;
  localparam int G = 8;
  localparam int D = N * G;

  logic           clk;
  logic           rst;
  logic           load_valid;
  logic [W-1:0]   load_data;
  logic           reload;
  logic           load_done;
  logic           in_valid;
  logic [N*W-1:0] in_data;
  logic           in_ready;
  logic           out_valid;
  logic [N*W-1:0] out_data;
  logic [2:0]     grp_idx;

  logic [W-1:0]   bias_model [D];
  logic [N*W-1:0] sb [$];
  logic [N*W-1:0] exp_v;
  logic [N*W-1:0] got_v;
  int             n_tests = 0;
  int             n_fail  = 0;
  int             exp_grp = 0;

  bias_add_bank #(
    .N_adder_tree (N),
    .WIDTH        (W),
    .GROUPS       (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .reload     (reload),
    .load_done  (load_done),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .grp_idx    (grp_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] lane_exp(input logic [W-1:0] b, input logic [W-1:0] d);
    logic signed [W:0] s;
    s = $signed({b[W-1], b}) + $signed({d[W-1], d});
`ifdef BIAS_SAT_EN
    if (s > 19'sh1FFFF) return 18'h1FFFF;
    else if (s < 19'sh60000) return 18'h20000;
    else return s[W-1:0];
`else
    return s[W-1:0];
`endif
  endfunction

  function automatic logic [N*W-1:0] make_exp(input logic [N*W-1:0] d, input int grp);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = lane_exp(bias_model[grp*N + k], d[k*W +: W]);
    return v;
  endfunction

  // mode 0: zeros, 1: +1 per lane, 2: -1 per lane, other: random
  function automatic logic [N*W-1:0] make_data(input int mode);
    logic [N*W-1:0] v;
    logic [31:0]    r;
    for (int k = 0; k < N; k++) begin
      r = $urandom();
      case (mode)
        0: v[k*W +: W] = 18'h00000;
        1: v[k*W +: W] = 18'h00001;
        2: v[k*W +: W] = 18'h3FFFF;
        default: v[k*W +: W] = r[W-1:0];
      endcase
    end
    return v;
  endfunction

  task automatic load_range(input int first, input int count);
    for (int a = first; a < first + count; a++) begin
      load_valid = 1'b1;
      load_data  = bias_model[a];
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; load_valid = 1'b1; in_valid = 1'b1; reload = 1'b1;
    @(negedge clk);
    n_tests++;
    if (load_done !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== '0 || grp_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got done=%b rdy=%b ov=%b grp=%0d od=%h exp all zero",
               load_done, in_ready, out_valid, grp_idx, out_data);
    end
    rst = 1'b0; load_valid = 1'b0; in_valid = 1'b0; reload = 1'b0;
  endtask

  task automatic test_in_valid_during_load;
    for (int a = 0; a < D; a++) bias_model[a] = 18'(a);
    for (int a = 0; a < D; a++) begin
      load_valid = 1'b1; load_data = bias_model[a];
      in_valid = 1'b1; in_data = make_data(3);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== (a == D - 1) || load_done !== (a == D - 1)) begin
        n_fail++;
        $display("FAIL load_gating addr=%0d got ov=%b rdy=%b done=%b exp ov=0 rdy=done=%b",
                 a, out_valid, in_ready, load_done, (a == D - 1));
      end
    end
    load_valid = 1'b0; in_valid = 1'b0;
    exp_grp = 0;
    n_tests++;
    if (grp_idx !== 3'd0) begin
      n_fail++; $display("FAIL load_grp0 got=%0d exp=0", grp_idx);
    end
  endtask

  task automatic test_load_run;
    for (int g = 0; g < G + 1; g++) begin
      n_tests++;
      if (grp_idx !== 3'(exp_grp)) begin
        n_fail++; $display("FAIL run_grp_idx beat=%0d got=%0d exp=%0d", g, grp_idx, exp_grp);
      end
      in_valid = 1'b1; in_data = make_data(0);
      sb.push_back(make_exp(in_data, exp_grp));
      @(negedge clk);
      in_valid = 1'b0;
      exp_v = sb.pop_front(); got_v = out_data;
      n_tests++;
      if (out_valid !== 1'b1 || got_v !== exp_v) begin
        n_fail++; $display("FAIL run_beat beat=%0d ov=%b got=%h exp=%h", g, out_valid, got_v, exp_v);
      end
      n_tests++;
      if (got_v[(N-1)*W +: W] !== 18'(16 * (g % G) + 15)) begin
        n_fail++; $display("FAIL run_lane15 beat=%0d got=%h exp=%h", g, got_v[(N-1)*W +: W], 18'(16 * (g % G) + 15));
      end
      exp_grp = (exp_grp + 1) % G;
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== got_v) begin
      n_fail++; $display("FAIL run_idle got ov=%b od=%h exp ov=0 od=%h", out_valid, out_data, got_v);
    end
  endtask

  task automatic test_load_valid_in_run;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1; load_data = 18'h2AAAA;
      @(negedge clk);
    end
    load_valid = 1'b0;
    n_tests++;
    if (load_done !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL run_load_ignored got done=%b rdy=%b exp 1 1", load_done, in_ready);
    end
    for (int g = 0; g < G; g++) begin
      in_valid = 1'b1; in_data = make_data(3);
      sb.push_back(make_exp(in_data, exp_grp));
      @(negedge clk);
      in_valid = 1'b0;
      exp_v = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp_v) begin
        n_fail++; $display("FAIL readback beat=%0d ov=%b got=%h exp=%h", g, out_valid, out_data, exp_v);
      end
      exp_grp = (exp_grp + 1) % G;
    end
  endtask

  task automatic test_reload_with_beat;
    for (int i = 0; i < G && exp_grp != 3; i++) begin
      in_valid = 1'b1; in_data = make_data(3);
      sb.push_back(make_exp(in_data, exp_grp));
      @(negedge clk);
      in_valid = 1'b0;
      exp_v = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp_v) begin
        n_fail++; $display("FAIL pre_reload beat=%0d got=%h exp=%h", i, out_data, exp_v);
      end
      exp_grp = (exp_grp + 1) % G;
    end
    n_tests++;
    if (grp_idx !== 3'd3) begin
      n_fail++; $display("FAIL reload_grp3 got=%0d exp=3", grp_idx);
    end
    in_valid = 1'b1; in_data = make_data(3); reload = 1'b1;
    sb.push_back(make_exp(in_data, 3));
    @(negedge clk);
    in_valid = 1'b0; reload = 1'b0;
    exp_v = sb.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== exp_v) begin
      n_fail++; $display("FAIL reload_beat ov=%b got=%h exp=%h", out_valid, out_data, exp_v);
    end
    n_tests++;
    if (load_done !== 1'b0 || grp_idx !== 3'd0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reload_state got done=%b grp=%0d rdy=%b exp 0 0 0", load_done, grp_idx, in_ready);
    end
    exp_grp = 0;
    // Partial load, then reload with a coincident load_valid, then a full load.
    for (int a = 0; a < D; a++) begin
      if (a < 16) bias_model[a] = 18'h1FFFF;
      else if (a < 32) bias_model[a] = 18'h20000;
      else bias_model[a] = 18'($urandom_range(0, 262143));
    end
    load_range(0, 5);
    reload = 1'b1; load_valid = 1'b1; load_data = 18'h15555;
    @(negedge clk);
    reload = 1'b0; load_valid = 1'b0;
    load_range(0, D - 1);
    n_tests++;
    if (load_done !== 1'b0) begin
      n_fail++; $display("FAIL reload_restart_early got done=%b exp=0", load_done);
    end
    load_range(D - 1, 1);
    n_tests++;
    if (load_done !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reload_restart_done got done=%b rdy=%b exp 1 1", load_done, in_ready);
    end
  endtask

  task automatic test_overflow;
    logic [W-1:0] sat_exp;
    for (int g = 0; g < G; g++) begin
      in_valid = 1'b1; in_data = make_data(g == 0 ? 1 : (g == 1 ? 2 : 3));
      sb.push_back(make_exp(in_data, exp_grp));
      @(negedge clk);
      in_valid = 1'b0;
      exp_v = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp_v) begin
        n_fail++; $display("FAIL ovf_beat beat=%0d ov=%b got=%h exp=%h", g, out_valid, out_data, exp_v);
      end
      if (g < 2) begin
`ifdef BIAS_SAT_EN
        sat_exp = (g == 0) ? 18'h1FFFF : 18'h20000;
`else
        sat_exp = (g == 0) ? 18'h20000 : 18'h1FFFF;
`endif
        n_tests++;
        if (out_data[7*W +: W] !== sat_exp) begin
          n_fail++; $display("FAIL ovf_lane7 beat=%0d got=%h exp=%h", g, out_data[7*W +: W], sat_exp);
        end
      end
      exp_grp = (exp_grp + 1) % G;
    end
  endtask

  task automatic test_rst_mid_load;
    in_valid = 1'b1; in_data = make_data(3); rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || load_done !== 1'b0 || in_ready !== 1'b0 || grp_idx !== 3'd0) begin
      n_fail++; $display("FAIL rst_beat got ov=%b done=%b rdy=%b grp=%0d exp all 0", out_valid, load_done, in_ready, grp_idx);
    end
    for (int a = 0; a < D; a++) bias_model[a] = 18'((a * 977) ^ 18'h2C3A5);
    load_range(0, 50);
    rst = 1'b1; load_valid = 1'b1; load_data = 18'h0F0F0;
    @(negedge clk);
    rst = 1'b0; load_valid = 1'b0;
    load_range(0, D - 1);
    n_tests++;
    if (load_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_load_early got done=%b exp=0", load_done);
    end
    load_range(D - 1, 1);
    n_tests++;
    if (load_done !== 1'b1) begin
      n_fail++; $display("FAIL rst_load_done got done=%b exp=1", load_done);
    end
    exp_grp = 0;
    for (int g = 0; g < G; g++) begin
      in_valid = 1'b1; in_data = make_data(3);
      sb.push_back(make_exp(in_data, exp_grp));
      @(negedge clk);
      in_valid = 1'b0;
      exp_v = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp_v) begin
        n_fail++; $display("FAIL post_rst_beat beat=%0d got=%h exp=%h", g, out_data, exp_v);
      end
      exp_grp = (exp_grp + 1) % G;
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; load_valid = 1'b0; load_data = '0;
    reload = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_in_valid_during_load;
    test_load_run;
    test_load_valid_in_run;
    test_reload_with_beat;
    test_overflow;
    test_rst_mid_load;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
